// File: rtl/rsc_inject_arbiter.sv
// Round-robin injection arbiter that feeds one router resource port of
// mesh_xy_noc from REQ_N local requesters, with a one-entry output register,
// back-pressure handling, stall detection, overflow flag and a sent counter.
//
// Handshake: requester k presents req_valid_i[k] plus its packet slice and
// holds both stable until it sees req_ready_o[k] high in the same cycle; that
// cycle the packet is captured. Downstream, rsc_wren_o is a write strobe that
// is only raised while the router's rsc_full_i is low in that same cycle.
module rsc_inject_arbiter #(
    parameter int REQ_N       = 4,
    parameter int ROW_N       = 3,
    parameter int COL_M       = 3,
    parameter int PCKT_DATA_W = 8,
    parameter int STALL_MAX   = 16,
    localparam int PACKET_W   = PCKT_DATA_W + $clog2(ROW_N) + $clog2(COL_M),
    localparam int IDX_W      = $clog2(REQ_N),
    localparam int STALL_W    = $clog2(STALL_MAX + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [REQ_N*PACKET_W-1:0] req_pckt_i,
    input  logic [REQ_N-1:0]          req_valid_i,
    output logic [REQ_N-1:0]          req_ready_o,
    output logic [PACKET_W-1:0]       rsc_pckt_o,
    output logic                      rsc_wren_o,
    input  logic                      rsc_full_i,
    input  logic                      rsc_ovrflw_i,
    output logic [IDX_W-1:0]          grant_idx_o,
    output logic                      stall_o,
    output logic                      ovrflw_err_o,
    output logic [15:0]               sent_cnt_o,
    output logic                      dbg_state_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]          state_q;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                load;
    logic [STALL_W-1:0]  stall_cnt_q;
    logic [PACKET_W-1:0] req_pckt [REQ_N];

    // Unpack the flat requester bus into one packet per requester.
    always_comb begin
        for (int k = 0; k < REQ_N; k++) begin
            req_pckt[k] = req_pckt_i[k*PACKET_W +: PACKET_W];
        end
    end

    // Round-robin search starting just after the previous winner, with wrap.
    always_comb begin
        int unsigned cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 1; i <= REQ_N; i++) begin
            cand = (int'(last_q) + i) % REQ_N;
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Write when holding and the router has room; load when the register is
    // free now or is being drained this same cycle, so streaming has no bubble.
    always_comb begin
        rsc_wren_o  = (state_q == ST_HOLD) && !rsc_full_i && rst_ni;
        load        = ((state_q == ST_EMPTY) || rsc_wren_o) && win_found && rst_ni;
        req_ready_o = '0;
        if (load) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // Output register, grant index, round-robin pointer and state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            rsc_pckt_o  <= '0;
            grant_idx_o <= '0;
            last_q      <= IDX_W'(REQ_N - 1);
        end else if (load) begin
            state_q     <= ST_HOLD;
            rsc_pckt_o  <= req_pckt[win_idx];
            grant_idx_o <= win_idx;
            last_q      <= win_idx;
        end else if (rsc_wren_o) begin
            state_q     <= ST_EMPTY;
        end
    end

    // Saturating count of back-pressured cycles while a packet is held.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || state_q == ST_EMPTY || rsc_wren_o) begin
            stall_cnt_q <= '0;
        end else if (rsc_full_i && stall_cnt_q != STALL_W'(STALL_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Sticky router overflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovrflw_err_o <= 1'b0;
        end else if (rsc_ovrflw_i) begin
            ovrflw_err_o <= 1'b1;
        end
    end

    // Wrapping count of packets written to the router.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sent_cnt_o <= '0;
        end else if (rsc_wren_o) begin
            sent_cnt_o <= sent_cnt_o + 16'd1;
        end
    end

    assign stall_o     = (stall_cnt_q == STALL_W'(STALL_MAX));
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rsc_inject_arbiter.sv
// Bench for rsc_inject_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_rsc_inject_arbiter;

  localparam int REQ_N       = 4;
  localparam int ROW_N       = 3;
  localparam int COL_M       = 3;
  localparam int PCKT_DATA_W = 8;
  localparam int STALL_MAX   = 16;
  localparam int PW          = PCKT_DATA_W + $clog2(ROW_N) + $clog2(COL_M);
  localparam int IW          = $clog2(REQ_N);

  // ---------------- clock / reset / DUT ----------------
  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [REQ_N*PW-1:0]   req_pckt_i = '0;
  logic [REQ_N-1:0]      req_valid_i = '0;
  logic [REQ_N-1:0]      req_ready_o;
  logic [PW-1:0]         rsc_pckt_o;
  logic                  rsc_wren_o;
  logic                  rsc_full_i = 1'b0;
  logic                  rsc_ovrflw_i = 1'b0;
  logic [IW-1:0]         grant_idx_o;
  logic                  stall_o;
  logic                  ovrflw_err_o;
  logic [15:0]           sent_cnt_o;
  logic                  dbg_state_o;

  always #5 clk_i = ~clk_i;

  rsc_inject_arbiter #(
    .REQ_N(REQ_N), .ROW_N(ROW_N), .COL_M(COL_M),
    .PCKT_DATA_W(PCKT_DATA_W), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_pckt_i(req_pckt_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsc_pckt_o(rsc_pckt_o), .rsc_wren_o(rsc_wren_o),
    .rsc_full_i(rsc_full_i), .rsc_ovrflw_i(rsc_ovrflw_i),
    .grant_idx_o(grant_idx_o), .stall_o(stall_o), .ovrflw_err_o(ovrflw_err_o),
    .sent_cnt_o(sent_cnt_o), .dbg_state_o(dbg_state_o)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0] exp_q[$];        // packet waiting in the output register (0 or 1 entry)
  logic [PW-1:0] m_pckt_out = '0; // value the output register shows
  int            m_idx = 0;
  int            m_last = REQ_N - 1;
  int            m_stall = 0;
  bit            m_ovf = 1'b0;
  logic [15:0]   m_sent = '0;

  function automatic int pick_winner(input logic [REQ_N-1:0] v, input int last);
    for (int i = 1; i <= REQ_N; i++) begin
      int c;
      c = (last + i) % REQ_N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  always begin : monitor
    logic [REQ_N-1:0] e_ready;
    logic e_wren, e_load, e_hold;
    int w;
    @(negedge clk_i);
    e_hold  = (exp_q.size() != 0);
    e_wren  = rst_ni && e_hold && !rsc_full_i;
    w       = pick_winner(req_valid_i, m_last);
    e_load  = rst_ni && (!e_hold || e_wren) && (w >= 0);
    e_ready = '0;
    if (e_load) e_ready[w] = 1'b1;
    if (mon_en) begin
      chk("mon_wren",  rsc_wren_o,   e_wren);
      chk("mon_ready", req_ready_o,  e_ready);
      chk("mon_pckt",  rsc_pckt_o,   m_pckt_out);
      chk("mon_grant", grant_idx_o,  m_idx);
      chk("mon_stall", stall_o,      (m_stall == STALL_MAX));
      chk("mon_ovf",   ovrflw_err_o, m_ovf);
      chk("mon_sent",  sent_cnt_o,   m_sent);
      chk("mon_state", dbg_state_o,  e_hold);
    end
    @(posedge clk_i);
    if (!rst_ni) begin
      exp_q.delete();
      m_pckt_out = '0;
      m_idx = 0;
      m_last = REQ_N - 1;
      m_stall = 0;
      m_ovf = 1'b0;
      m_sent = '0;
    end else begin
      if (e_wren) m_sent = m_sent + 16'd1;
      if (!e_hold || e_wren) m_stall = 0;
      else if (rsc_full_i && m_stall < STALL_MAX) m_stall++;
      if (rsc_ovrflw_i) m_ovf = 1'b1;
      if (e_wren) void'(exp_q.pop_front());
      if (e_load) begin
        exp_q.push_back(req_pckt_i[w*PW +: PW]);
        m_pckt_out = req_pckt_i[w*PW +: PW];
        m_idx = w;
        m_last = w;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = '0;
    rsc_full_i = 1'b0;
    rsc_ovrflw_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic set_pkt(input int k, input logic [PW-1:0] v);
    req_pckt_i[k*PW +: PW] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [REQ_N-1:0] acc;
    logic [REQ_N-1:0] exp_rdy;

    // Reset state
    do_reset();
    mon_en = 1'b1;
    #1;
    chk("rst_grant", grant_idx_o, 0);
    chk("rst_pckt", rsc_pckt_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_ovf", ovrflw_err_o, 0);
    chk("rst_sent", sent_cnt_o, 0);
    chk("rst_state", dbg_state_o, 0);

    // Single requester 2 with packet 0x2A5
    set_pkt(2, 12'h2A5);
    req_valid_i = 4'b0100;
    #1;
    chk("t1_ready", req_ready_o, 4'b0100);
    chk("t1_wren_c1", rsc_wren_o, 0);
    step();
    req_valid_i = '0;
    #1;
    chk("t1_wren_c2", rsc_wren_o, 1);
    chk("t1_pckt", rsc_pckt_o, 12'h2A5);
    chk("t1_grant", grant_idx_o, 2);
    step();
    #1;
    chk("t1_sent", sent_cnt_o, 1);
    chk("t1_wren_c3", rsc_wren_o, 0);

    // All four requesters streaming: grants rotate, one write per cycle
    do_reset();
    for (int k = 0; k < REQ_N; k++) set_pkt(k, PW'(12'h0A0 + k));
    req_valid_i = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_rdy = 4'b0001 << (i % 4);
      chk("t2_grant_order", req_ready_o, exp_rdy);
      if (i > 0) begin
        chk("t2_wren", rsc_wren_o, 1);
        chk("t2_pckt", rsc_pckt_o, PW'(12'h0A0 + ((i - 1) % 4)));
      end
      step();
    end
    req_valid_i = '0;
    #1;
    chk("t2_last_wren", rsc_wren_o, 1);
    chk("t2_last_pckt", rsc_pckt_o, 12'h0A3);
    step();
    #1;
    chk("t2_sent", sent_cnt_o, 8);

    // Back-pressure for 20 cycles while holding
    do_reset();
    set_pkt(1, 12'h5C3);
    req_valid_i = 4'b0010;
    #1;
    chk("t3_ready", req_ready_o, 4'b0010);
    step();
    set_pkt(3, 12'h777);
    req_valid_i = 4'b1000;
    rsc_full_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      chk("t3_wren", rsc_wren_o, 0);
      chk("t3_ready_full", req_ready_o, 0);
      chk("t3_pckt_hold", rsc_pckt_o, 12'h5C3);
      chk("t3_grant_hold", grant_idx_o, 1);
      chk("t3_stall", stall_o, (i >= 17));
      step();
    end
    rsc_full_i = 1'b0;
    #1;
    chk("t3_rel_wren", rsc_wren_o, 1);
    chk("t3_rel_pckt", rsc_pckt_o, 12'h5C3);
    chk("t3_rel_stall", stall_o, 1);
    chk("t3_rel_ready", req_ready_o, 4'b1000);
    step();
    req_valid_i = '0;
    #1;
    chk("t3_stall_drop", stall_o, 0);
    chk("t3_next_pckt", rsc_pckt_o, 12'h777);

    // Overflow pulse sets a sticky flag
    step();
    #1;
    chk("t4_ovf_before", ovrflw_err_o, 0);
    rsc_ovrflw_i = 1'b1;
    step();
    rsc_ovrflw_i = 1'b0;
    #1;
    chk("t4_ovf_set", ovrflw_err_o, 1);
    repeat (5) step();
    #1;
    chk("t4_ovf_sticky", ovrflw_err_o, 1);

    // Reset while a packet is held under back-pressure
    set_pkt(2, 12'h2A5);
    req_valid_i = 4'b0100;
    step();
    req_valid_i = '0;
    rsc_full_i = 1'b1;
    repeat (3) step();
    rst_ni = 1'b0;
    req_valid_i = '1;
    #1;
    chk("t5_rst_wren", rsc_wren_o, 0);
    chk("t5_rst_ready", req_ready_o, 0);
    step();
    #1;
    chk("t5_rst_wren2", rsc_wren_o, 0);
    chk("t5_rst_ready2", req_ready_o, 0);
    rsc_full_i = 1'b0;
    set_pkt(0, 12'h0F0);
    rst_ni = 1'b1;
    #1;
    chk("t5_state", dbg_state_o, 0);
    chk("t5_sent", sent_cnt_o, 0);
    chk("t5_stall", stall_o, 0);
    chk("t5_ovf", ovrflw_err_o, 0);
    chk("t5_first_grant", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0;
    #1;
    chk("t5_pckt", rsc_pckt_o, 12'h0F0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rsc_full_i   = ((n % 300) < 30) ? 1'b1 : ($urandom_range(0, 99) < 35);
      rsc_ovrflw_i = ($urandom_range(0, 299) == 0);
      rst_ni       = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < REQ_N; k++) begin
        if (!req_valid_i[k] && $urandom_range(0, 99) < 50) begin
          set_pkt(k, PW'($urandom));
          req_valid_i[k] = 1'b1;
        end
      end
      #1;
      acc = req_ready_o;
      step();
      for (int k = 0; k < REQ_N; k++) begin
        if (acc[k]) req_valid_i[k] = 1'b0;
      end
    end

    // Sent counter wrap: 65535 writes reach 0xFFFF, one more wraps to 0
    do_reset();
    set_pkt(0, 12'h123);
    req_valid_i = 4'b0001;
    repeat (65536) step();
    #1;
    chk("t6_sent_ffff", sent_cnt_o, 16'hFFFF);
    chk("t6_wren", rsc_wren_o, 1);
    step();
    req_valid_i = '0;
    #1;
    chk("t6_sent_wrap", sent_cnt_o, 16'h0000);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
